// File: rtl/series_serializer_pkg.sv
// Shared constants for the serializer and the serial pattern detectors it feeds:
// one-hot state encodings and the default word width.
package series_serializer_pkg;

  localparam logic [1:0] SER_IDLE   = 2'b01;
  localparam logic [1:0] SER_SHIFT  = 2'b10;
  localparam int         SER_DATA_W = 8;

endpackage

// File: rtl/series_serializer.sv
// Parallel-to-serial converter with a one-word hold buffer for gapless streaming.
// Define SERIALIZER_PARITY_EN to append an even-parity bit after each word.
module series_serializer
  import series_serializer_pkg::*;
#(
  parameter int   DATA_W    = SER_DATA_W,
  parameter logic MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              series,
  output logic              series_valid,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);
`ifdef SERIALIZER_PARITY_EN
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_DLAST = CNT_W'(DATA_W - 1);
`else
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DATA_W - 1);
`endif

  logic [1:0]        state_reg;
  logic [DATA_W-1:0] sr_reg;
  logic [DATA_W-1:0] hr_reg;
  logic              hold_v_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              series_reg;
  logic              series_valid_reg;
`ifdef SERIALIZER_PARITY_EN
  logic              parity_reg;
`endif

  // The bit at the "head" of a word is the one that goes out first.
  function automatic logic head_bit(input logic [DATA_W-1:0] w);
    if (MSB_FIRST) return w[DATA_W-1];
    else           return w[0];
  endfunction

  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
    if (MSB_FIRST) return {w[DATA_W-2:0], 1'b0};
    else           return {1'b0, w[DATA_W-1:1]};
  endfunction

  logic              in_shift;
  logic              last_cycle;
  logic              accept;
  logic              load;
  logic [DATA_W-1:0] load_word;
  logic [DATA_W-1:0] sr_adv;

  assign in_ready   = !hold_v_reg;
  assign accept     = in_valid && !hold_v_reg;
  assign in_shift   = (state_reg == SER_SHIFT);
  assign last_cycle = in_shift && (cnt_reg == CNT_LAST);
  assign load       = last_cycle ? (hold_v_reg || accept) : (!in_shift && accept);
  // A pending held word always wins over a bypass at the word boundary.
  assign load_word  = (last_cycle && hold_v_reg) ? hr_reg : in_data;
  assign sr_adv     = advance(sr_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= SER_IDLE;
      sr_reg           <= '0;
      hr_reg           <= '0;
      hold_v_reg       <= 1'b0;
      cnt_reg          <= '0;
      series_reg       <= IDLE_BIT;
      series_valid_reg <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      parity_reg       <= 1'b0;
`endif
    end else begin
      if (load) begin
        state_reg        <= SER_SHIFT;
        sr_reg           <= load_word;
        series_reg       <= head_bit(load_word);
        series_valid_reg <= 1'b1;
        cnt_reg          <= '0;
`ifdef SERIALIZER_PARITY_EN
        parity_reg       <= ^load_word;
`endif
      end else if (in_shift && !last_cycle) begin
        sr_reg  <= sr_adv;
        cnt_reg <= cnt_reg + CNT_W'(1);
`ifdef SERIALIZER_PARITY_EN
        series_reg <= (cnt_reg == CNT_DLAST) ? parity_reg : head_bit(sr_adv);
`else
        series_reg <= head_bit(sr_adv);
`endif
      end else if (last_cycle) begin
        state_reg        <= SER_IDLE;
        series_reg       <= IDLE_BIT;
        series_valid_reg <= 1'b0;
        cnt_reg          <= '0;
      end

      if (last_cycle && hold_v_reg) begin
        hold_v_reg <= 1'b0;
      end else if (accept && !load) begin
        hr_reg     <= in_data;
        hold_v_reg <= 1'b1;
      end
    end
  end

  assign series       = series_reg;
  assign series_valid = series_valid_reg;
  assign busy         = in_shift || hold_v_reg;

endmodule

// File: doc/series_serializer.md
Name: series_serializer

Overview:
- Upstream stage of the serial pattern detectors.
- Takes parallel words on a valid/ready handshake and emits them one bit per clock on `series`, with a qualifying `series_valid`.
- Drives the detectors' `series` input directly.
- One word of buffering, so back-to-back words stream with no idle bit between them.

Parameters:
- DATA_W, 8, word width in bits; legal range 2..32.
- MSB_FIRST, 1'b1, 1 = bit DATA_W-1 is sent first; 0 = bit 0 is sent first.
- IDLE_BIT, 1'b0, value driven on `series` when no word is being shifted.

Ports:
- clk  input  1  system clock, all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  DATA_W  parallel word to serialize.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- series  output  1  serial bit stream (registered).
- series_valid  output  1  `series` carries a data (or parity) bit this cycle (registered).
- busy  output  1  shift in progress or hold buffer occupied.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - series = IDLE_BIT, series_valid = 0, busy = 0.
  - Hold buffer empty, bit counter 0, state IDLE.
  - in_ready = 1 immediately after reset deasserts.
- Storage: shift register SR (DATA_W), hold register HR (DATA_W) with flag hold_v, bit counter CNT of width clog2(DATA_W+1).
- in_ready = !hold_v, combinational from a register only; it never depends on in_valid.
- Accept = in_valid && in_ready. in_data is sampled only on accept.
- States are one-hot:
  - IDLE: series = IDLE_BIT, series_valid = 0. On accept, load SR and go to SHIFT.
  - SHIFT: every cycle, drive the next SR bit on series with series_valid = 1 and increment CNT.
- Latency: the first bit of an accepted word appears on series the cycle after accept. A word occupies exactly DATA_W consecutive cycles.
- Last-bit cycle (CNT = DATA_W-1), in priority order:
  - hold_v = 1: reload SR from HR, clear hold_v, stay in SHIFT. No gap.
  - hold_v = 0 and accept this cycle: load SR directly from in_data (bypass), stay in SHIFT. No gap.
  - Otherwise: go to IDLE. series returns to IDLE_BIT next cycle.
- Accept during SHIFT but not on the last bit: word goes to HR, hold_v = 1, in_ready drops the next cycle.
- Simultaneous reload from HR and a new accept cannot happen, because in_ready = 0 whenever hold_v = 1.
- Bit order is fixed by MSB_FIRST.
- CNT wraps to 0 on every reload.
- busy = state SHIFT || hold_v.
- Reset asserted mid-word: the partial word and the held word are discarded, all outputs return to reset values asynchronously, and no partial output resumes after reset.
- in_valid held high with changing in_data while in_ready = 0 is ignored; nothing is sampled.

Optional Feature:
- Macro SERIALIZER_PARITY_EN.
- Defined:
  - After the last data bit of each word, one extra cycle drives the even-parity bit (XOR of the word) with series_valid = 1.
  - Each word therefore takes DATA_W+1 cycles.
  - The reload/bypass decisions move to the parity cycle (CNT = DATA_W).
- Undefined: no parity logic is present, and each word takes DATA_W cycles.

Decomposition:
- Shared package holds:
  - one-hot state constants SER_IDLE = 2'b01, SER_SHIFT = 2'b10;
  - default width constant SER_DATA_W = 8.
- The detector blocks use the same package for their series-width assumptions.
- No sub-module is needed. CNT and SR stay inline; the block is a single module.

Test Plan:
- MSB_FIRST = 1, accept 8'h0B in IDLE:
  - series = 0,0,0,0,1,0,1,1 on the 8 cycles after accept, series_valid high for exactly those 8 cycles;
  - a downstream 1011 detector fires once.
- Back-to-back 8'hB0, 8'hFF, 8'h00 with in_valid held high:
  - 24 contiguous valid bits, no gap;
  - in_ready low from the cycle after the 2nd accept until the 1st word's last bit.
- in_valid first asserted on the last-bit cycle with HR empty: bypass load, next word's first bit follows with no gap, hold_v stays 0.
- Assert rst_n low at bit 3 of 8'hA5 with 8'h3C held:
  - series = IDLE_BIT, series_valid = 0, busy = 0 immediately;
  - after release, idle output until a new accept.
- MSB_FIRST = 0, word 8'h0D: series = 1,0,1,1,0,0,0,0.
- SERIALIZER_PARITY_EN defined, word 8'h07: 8 data bits followed by parity bit 1; the next word starts on cycle 10 after accept.
